// File: rtl/io_confirm_ctrl.sv
// io_confirm_ctrl: sequences memory-mapped IO accesses from the MEM stage.
// An IO read stalls the pipeline until a debounced confirm press, then
// captures the synchronised switches. An IO write loads the output register
// in a single cycle with no stall.
module io_confirm_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SW_WIDTH        = 16,
  parameter int OUT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 io_read_i,
  input  logic                 io_write_i,
  input  logic [OUT_WIDTH-1:0] wdata_i,
  input  logic                 confirm_i,
  input  logic [SW_WIDTH-1:0]  switch_i,
  output logic                 stall_o,
  output logic [SW_WIDTH-1:0]  rdata_o,
  output logic                 rdata_valid_o,
  output logic [OUT_WIDTH-1:0] led_o,
  output logic [1:0]           state_o
);

  // A one-bit counter is kept even when a single cycle of agreement suffices.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_REL   = 2'd1,
    WAIT_PRESS = 2'd2,
    CAPTURE    = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 cf_p0;
  logic                 cf_p1;
  logic [SW_WIDTH-1:0]  sw_p0;
  logic [SW_WIDTH-1:0]  sw_p1;
  logic                 db;
  logic [CNT_W-1:0]     cnt;
  logic                 press;
  logic                 cap_en;
  logic                 led_en;

  // --- stage p0/p1: two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cf_p0 <= 1'b0;
      cf_p1 <= 1'b0;
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      cf_p0 <= confirm_i;
      cf_p1 <= cf_p0;
      sw_p0 <= switch_i;
      sw_p1 <= sw_p0;
    end
  end

  // --- debouncer: db follows cf_p1 only after DEBOUNCE_CYCLES of disagreement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (cf_p1 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      db  <= cf_p1;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // A press is the edge at which db is about to flip from 0 to 1.
  assign press = ~db & cf_p1 & (cnt == CNT_MAX);

  // FSM state register; reset abandons any read in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A read takes priority over a simultaneous write, and a
  // still-held button must be released before it can complete a new read.
  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    led_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_read_i) begin
          state_d = db ? WAIT_REL : WAIT_PRESS;
        end else if (io_write_i) begin
          led_en = 1'b1;
        end
      end
      WAIT_REL: begin
        if (!db) begin
          state_d = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (press) begin
          cap_en  = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // The read instruction is still in MEM here; it must not restart.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and read-data registers, loaded only on their enable conditions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_o   <= '0;
      rdata_o <= '0;
    end else begin
      if (led_en) begin
        led_o <= wdata_i;
      end
      if (cap_en) begin
        rdata_o <= sw_p1;
      end
    end
  end

  // Stall is combinational on the IDLE term so the read freezes from its
  // first MEM cycle; it is released in CAPTURE so write-back can proceed.
  always_comb begin
    stall_o       = ~rst & (((state_q == IDLE) & io_read_i) |
                            (state_q == WAIT_REL) | (state_q == WAIT_PRESS));
    rdata_valid_o = (state_q == CAPTURE);
    state_o       = state_q;
  end

endmodule

// File: tb/tb_io_confirm_ctrl.sv
// Testbench for io_confirm_ctrl with a short debounce window.
module tb_io_confirm_ctrl;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam int OW = 32;
  localparam int VW = 2 + 1 + 1 + SW + OW;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          io_read  = 1'b0;
  logic          io_write = 1'b0;
  logic [OW-1:0] wdata    = '0;
  logic          confirm  = 1'b0;
  logic [SW-1:0] sw       = '0;

  logic          stall_o;
  logic [SW-1:0] rdata_o;
  logic          rdata_valid_o;
  logic [OW-1:0] led_o;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int dut_caps = 0;

  io_confirm_ctrl #(
    .DEBOUNCE_CYCLES(N),
    .SW_WIDTH(SW),
    .OUT_WIDTH(OW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_read_i(io_read),
    .io_write_i(io_write),
    .wdata_i(wdata),
    .confirm_i(confirm),
    .switch_i(sw),
    .stall_o(stall_o),
    .rdata_o(rdata_o),
    .rdata_valid_o(rdata_valid_o),
    .led_o(led_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: history of raw button samples, a debounced level that
  // flips once the last N synchronised samples all disagree with it, and the
  // read/write sequencing rules.
  logic          samp [0:N];
  logic [SW-1:0] sw_h [0:1];
  logic          m_db;
  logic [1:0]    m_state;
  logic [OW-1:0] m_led;
  logic [SW-1:0] m_rdata;
  int            m_caps = 0;

  function automatic logic db_flips();
    logic all_diff;
    all_diff = 1'b1;
    for (int j = 1; j <= N; j++) begin
      if (samp[j] == m_db) all_diff = 1'b0;
    end
    return all_diff;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= N; k++) samp[k] <= 1'b0;
      sw_h[0] <= '0;
      sw_h[1] <= '0;
      m_db    <= 1'b0;
      m_state <= 2'd0;
      m_led   <= '0;
      m_rdata <= '0;
    end else begin
      case (m_state)
        2'd0: begin
          if (io_read) m_state <= m_db ? 2'd1 : 2'd2;
          else if (io_write) m_led <= wdata;
        end
        2'd1: if (!m_db) m_state <= 2'd2;
        2'd2: begin
          if (db_flips() && !m_db) begin
            m_rdata <= sw_h[1];
            m_state <= 2'd3;
            m_caps  <= m_caps + 1;
          end
        end
        default: m_state <= 2'd0;
      endcase
      if (db_flips()) m_db <= ~m_db;
      samp[0] <= confirm;
      for (int k = 1; k <= N; k++) samp[k] <= samp[k-1];
      sw_h[0] <= sw;
      sw_h[1] <= sw_h[0];
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    logic st;
    st = !rst && ((m_state == 2'd0 && io_read) || m_state == 2'd1 || m_state == 2'd2);
    return {m_state, st, (m_state == 2'd3), m_rdata, m_led};
  endfunction

  logic [VW-1:0] obs;
  assign obs = {state_o, stall_o, rdata_valid_o, rdata_o, led_o};

  always @(negedge clk) begin
    if (rdata_valid_o === 1'b1) dut_caps <= dut_caps + 1;
  end

  task automatic test_reset();
    logic [OW-1:0] w;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== '0) $display("FAIL reset_state: got %h expected 0", obs);
    else n_pass++;
    w = $urandom;
    wdata = w; io_write = 1'b1;
    @(negedge clk);
    io_write = 1'b0;
    n_checks++;
    if (led_o !== w) $display("FAIL first_write: led %h expected %h", led_o, w);
    else n_pass++;
    io_read = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== exp_vec()) $display("FAIL pre_reset_wait: got %h expected %h", obs, exp_vec());
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== '0) $display("FAIL async_reset: got %h expected 0", obs);
    else n_pass++;
    @(negedge clk);
    io_read = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    wdata = 32'hDEADBEEF; io_write = 1'b1;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) $display("FAIL write_no_stall: stall %b expected 0", stall_o);
    else n_pass++;
    @(negedge clk);
    io_write = 1'b0;
    n_checks++;
    if (led_o !== 32'hDEADBEEF || stall_o !== 1'b0)
      $display("FAIL write_deadbeef: led %h stall %b expected deadbeef 0", led_o, stall_o);
    else n_pass++;
  endtask

  task automatic test_basic_read();
    int k;
    confirm = 1'b0; sw = 16'h1234;
    repeat (8) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL basic_idle: got %h expected %h", obs, exp_vec());
      else n_pass++;
    end
    io_read = 1'b1;
    #1;
    n_checks++;
    if (stall_o !== 1'b1 || state_o !== 2'd0)
      $display("FAIL read_stall_same_cycle: stall %b state %0d expected 1 0", stall_o, state_o);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (state_o !== 2'd2 || stall_o !== 1'b1)
      $display("FAIL enter_wait_press: state %0d stall %b expected 2 1", state_o, stall_o);
    else n_pass++;
    confirm = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL basic_cycle: got %h expected %h", obs, exp_vec());
      else n_pass++;
      if (rdata_valid_o === 1'b1) break;
    end
    n_checks++;
    if (k != 5) $display("FAIL press_latency: capture after edge %0d expected 5", k);
    else n_pass++;
    n_checks++;
    if (rdata_o !== 16'h1234 || stall_o !== 1'b0)
      $display("FAIL basic_capture: rdata %h stall %b expected 1234 0", rdata_o, stall_o);
    else n_pass++;
    io_read = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rdata_valid_o !== 1'b0 || state_o !== 2'd0 || rdata_o !== 16'h1234)
      $display("FAIL capture_one_cycle: valid %b state %0d rdata %h expected 0 0 1234",
               rdata_valid_o, state_o, rdata_o);
    else n_pass++;
    confirm = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_held_button();
    int k;
    int caps0;
    logic [SW-1:0] v;
    confirm = 1'b1;
    repeat (8) @(negedge clk);
    caps0 = dut_caps;
    v = SW'($urandom);
    sw = v;
    io_read = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state_o !== 2'd1 || stall_o !== 1'b1)
      $display("FAIL wait_rel: state %0d stall %b expected 1 1", state_o, stall_o);
    else n_pass++;
    repeat ($urandom_range(3, 9)) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL held_cycle: got %h expected %h", obs, exp_vec());
      else n_pass++;
    end
    confirm = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL release_cycle: got %h expected %h", obs, exp_vec());
      else n_pass++;
      if (state_o === 2'd2) break;
    end
    n_checks++;
    if (k == 40) $display("FAIL held_release_timeout: state %0d expected 2", state_o);
    else n_pass++;
    confirm = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL held_press_cycle: got %h expected %h", obs, exp_vec());
      else n_pass++;
      if (rdata_valid_o === 1'b1) break;
    end
    n_checks++;
    if (k == 20 || rdata_o !== v)
      $display("FAIL held_capture: edges %0d rdata %h expected <20 %h", k, rdata_o, v);
    else n_pass++;
    io_read = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (dut_caps - caps0 != 1) $display("FAIL held_one_capture: %0d captures expected 1", dut_caps - caps0);
    else n_pass++;
    confirm = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_glitch();
    int k;
    int len;
    int caps0;
    logic [SW-1:0] v;
    io_read = 1'b1;
    sw = SW'($urandom);
    @(negedge clk);
    caps0 = dut_caps;
    repeat (3) begin
      len = $urandom_range(1, N - 1);
      confirm = 1'b1;
      repeat (len) @(negedge clk);
      confirm = 1'b0;
      repeat (8) begin
        @(negedge clk);
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL glitch_cycle: got %h expected %h", obs, exp_vec());
        else n_pass++;
      end
    end
    n_checks++;
    if (dut_caps != caps0 || state_o !== 2'd2 || stall_o !== 1'b1)
      $display("FAIL glitch_rejected: caps %0d state %0d stall %b expected 0 2 1",
               dut_caps - caps0, state_o, stall_o);
    else n_pass++;
    v = SW'($urandom);
    sw = v;
    len = $urandom_range(N, N + 3);
    confirm = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL long_press_cycle: got %h expected %h", obs, exp_vec());
      else n_pass++;
      if (rdata_valid_o === 1'b1) break;
      confirm = (k + 1 < len);
    end
    n_checks++;
    if (k != N + 1 || rdata_o !== v)
      $display("FAIL glitch_then_capture: edge %0d rdata %h expected %0d %h", k, rdata_o, N + 1, v);
    else n_pass++;
    io_read = 1'b0;
    confirm = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int k;
    int caps0;
    logic [OW-1:0] w0;
    logic [SW-1:0] v;
    w0 = $urandom;
    wdata = w0; io_write = 1'b1;
    @(negedge clk);
    caps0 = dut_caps;
    v = SW'($urandom);
    sw = v;
    io_read = 1'b1; io_write = 1'b1; wdata = ~w0;
    @(negedge clk);
    repeat (3) begin
      wdata = $urandom; io_write = 1'($urandom);
      @(negedge clk);
    end
    confirm = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL simul_cycle: got %h expected %h", obs, exp_vec());
      else n_pass++;
      if (rdata_valid_o === 1'b1) break;
      wdata = $urandom; io_write = 1'($urandom);
    end
    n_checks++;
    if (k == 20 || led_o !== w0 || rdata_o !== v)
      $display("FAIL simul_read_wins: edge %0d led %h rdata %h expected %h %h", k, led_o, rdata_o, w0, v);
    else n_pass++;
    io_write = 1'b0;
    v = SW'($urandom) | 16'h0001;
    sw = v;
    @(negedge clk);
    n_checks++;
    if (state_o !== 2'd0 || stall_o !== 1'b1)
      $display("FAIL b2b_idle_gap: state %0d stall %b expected 0 1", state_o, stall_o);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (state_o !== 2'd1) $display("FAIL b2b_wait_rel: state %0d expected 1", state_o);
    else n_pass++;
    confirm = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (state_o === 2'd2) break;
    end
    confirm = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL b2b_cycle: got %h expected %h", obs, exp_vec());
      else n_pass++;
      if (rdata_valid_o === 1'b1) break;
    end
    io_read = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut_caps - caps0 != 2 || rdata_o !== v || led_o !== w0)
      $display("FAIL b2b_two_captures: caps %0d rdata %h led %h expected 2 %h %h",
               dut_caps - caps0, rdata_o, led_o, v, w0);
    else n_pass++;
    confirm = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_midwait();
    io_read = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (state_o !== 2'd2 || rdata_o === '0)
      $display("FAIL midwait_setup: state %0d rdata %h expected 2 nonzero", state_o, rdata_o);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (stall_o !== 1'b0 || rdata_o !== '0 || state_o !== 2'd0)
      $display("FAIL midwait_reset: stall %b rdata %h state %0d expected 0 0 0", stall_o, rdata_o, state_o);
    else n_pass++;
    @(negedge clk);
    io_read = 1'b0;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL post_reset_cycle: got %h expected %h", obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (state_o !== 2'd0 || stall_o !== 1'b0)
      $display("FAIL post_reset_idle: state %0d stall %b expected 0 0", state_o, stall_o);
    else n_pass++;
  endtask

  task automatic test_random();
    int run;
    int caps_d0;
    int caps_m0;
    run = 0;
    caps_d0 = dut_caps;
    caps_m0 = m_caps;
    repeat (400) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL random_cycle: got %h expected %h", obs, exp_vec());
      else n_pass++;
      if (io_read && m_state == 2'd3) io_read = 1'b0;
      else if (!io_read && m_state == 2'd0 && $urandom_range(0, 7) == 0) io_read = 1'b1;
      io_write = ($urandom_range(0, 2) == 0);
      wdata = $urandom;
      sw = SW'($urandom);
      if (run == 0) begin
        confirm = 1'($urandom);
        run = $urandom_range(1, 2 * N);
      end
      run--;
    end
    io_read = 1'b0; io_write = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut_caps - caps_d0 != m_caps - caps_m0)
      $display("FAIL random_capture_count: %0d captures expected %0d", dut_caps - caps_d0, m_caps - caps_m0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_held_button();
    test_glitch();
    test_simultaneous();
    test_reset_midwait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
